axis_noc_ejection_buffer: RTL and testbench
===========================================

AXIS_NOC_EJECTION_BUFFER -- requirements
Module: axis_noc_ejection_buffer

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 128, meaning flit payload width and AXI-stream tdata width (serialization factor 1).
REQ-002 SHALL have parameter TID_WIDTH, default 2, meaning AXI-stream tid width.
REQ-003 SHALL have parameter TDEST_WIDTH, default 4, meaning AXI-stream tdest width.
REQ-004 SHALL have parameter DEST_WIDTH, default TDEST_WIDTH+TID_WIDTH, meaning router flit destination width.
REQ-005 SHALL have parameter FLIT_BUFFER_DEPTH, default 2, legal range 1..64, meaning flit FIFO entries and the upstream initial credit count.
REQ-006 SHALL have parameter PKT_COUNT_WIDTH, default 16, meaning width of the completed-packet counter.
REQ-007 SHALL have port clk_noc, input, 1, the single clock; all logic is on rising edge.
REQ-008 SHALL have port rst_noc_sync, input, 1, reset; synchronous, active-high.
REQ-009 SHALL have port data_in, input, FLIT_WIDTH, flit payload from the router local output port.
REQ-010 SHALL have port dest_in, input, DEST_WIDTH, flit destination {tid, tdest}.
REQ-011 SHALL have port is_tail_in, input, 1, last flit of packet.
REQ-012 SHALL have port send_in, input, 1, flit valid this cycle.
REQ-013 SHALL have port credit_out, input-to-router, output, 1, one-cycle pulse returning one buffer credit.
REQ-014 SHALL have ports axis_out_tvalid (output, 1), axis_out_tready (input, 1), axis_out_tdata (output, FLIT_WIDTH), axis_out_tlast (output, 1), axis_out_tid (output, TID_WIDTH), axis_out_tdest (output, TDEST_WIDTH), AXI4-Stream master.
REQ-015 SHALL have port overflow_err, output, 1, sticky flag: a flit arrived with no free entry.
REQ-016 SHALL have port pkt_count, output, PKT_COUNT_WIDTH, count of tail flits delivered on AXI-stream.
REQ-017 SHALL have port in_packet, output, 1, high between a delivered non-tail flit and the next delivered tail flit.

Function
REQ-018 SHALL write {data_in, dest_in, is_tail_in} into a circular FIFO of FLIT_BUFFER_DEPTH entries on every cycle send_in=1 and the push is legal.
REQ-019 SHALL define push legal as: FIFO not full, or FIFO full with a pop in the same cycle.
REQ-020 SHALL drop a flit arriving when full with no same-cycle pop, leave FIFO contents unchanged, and set overflow_err=1 from the next cycle until reset.
REQ-021 SHALL drive axis_out_tvalid=1 whenever the FIFO is non-empty, presenting the head entry; a flit with send_in at cycle N SHALL be visible on AXI-stream at cycle N+1 when the FIFO was empty.
REQ-022 SHALL pop the head entry on cycle where axis_out_tvalid=1 and axis_out_tready=1.
REQ-023 SHALL hold tdata/tlast/tid/tdest stable while tvalid=1 and tready=0.
REQ-024 SHALL map axis_out_tid = head dest[DEST_WIDTH-1:TDEST_WIDTH], axis_out_tdest = head dest[TDEST_WIDTH-1:0], axis_out_tlast = head is_tail.
REQ-025 SHALL assert credit_out for exactly one cycle, in the cycle after each pop; N back-to-back pops SHALL give N consecutive credit pulses.
REQ-026 SHALL NOT return a credit for a dropped flit.
REQ-027 SHALL track occupancy 0..FLIT_BUFFER_DEPTH; simultaneous push and pop SHALL leave occupancy unchanged; pointers SHALL wrap from FLIT_BUFFER_DEPTH-1 to 0 (non-power-of-two depths included).
REQ-028 SHALL implement packet state machine IDLE/IN_PKT on pops: IDLE->IN_PKT on pop with tlast=0; IN_PKT->IDLE on pop with tlast=1; single-flit packet (tlast=1 in IDLE) stays IDLE; in_packet=1 iff state IN_PKT.
REQ-029 SHALL increment pkt_count by 1 on every pop with tlast=1, wrapping modulo 2^PKT_COUNT_WIDTH.
REQ-030 SHALL have no combinational path from send_in or axis_out_tready to any output.

Reset
REQ-031 SHALL, with rst_noc_sync=1 at a rising edge, empty the FIFO, set state IDLE, and from the next cycle drive axis_out_tvalid=0, credit_out=0, overflow_err=0, pkt_count=0, in_packet=0.
REQ-032 SHALL ignore send_in and axis_out_tready while rst_noc_sync=1; reset mid-packet SHALL discard buffered flits without issuing credits.
REQ-033 SHALL leave tdata/tlast/tid/tdest don't-care while axis_out_tvalid=0.

Verification
REQ-034 Single flit: send_in=1, data=0xA5.., dest=6'b10_0011, tail=1, tready=1 -> cycle+1 tvalid=1, tid=2, tdest=3, tlast=1; cycle+2 credit_out=1 and pkt_count=1.
REQ-035 Backpressure: depth 2, tready=0, send 2 flits -> tvalid held, no credit_out; raise tready -> 2 pops, 2 consecutive credit pulses, data order preserved.
REQ-036 Overflow: depth 2 full, tready=0, third send_in -> overflow_err=1 next cycle and sticky, FIFO data unchanged, only 2 credits ever returned.
REQ-037 Full with simultaneous push/pop: full, tready=1 and send_in=1 same cycle -> push accepted, overflow_err=0, occupancy stays 2.
REQ-038 Packet tracking: 3-flit packet then 1-flit packet, tready=1 -> in_packet high after first pop until third pop; pkt_count 0->1->2; pkt_count wraps 0xFFFF->0.
REQ-039 Reset mid-packet: two flits buffered, assert rst_noc_sync one cycle -> tvalid=0, pkt_count=0, in_packet=0, no credit_out pulse.

Source files
------------

// File: rtl/axis_noc_ejection_buffer.sv
// NoC ejection buffer: stores router flits in a small circular FIFO, presents them as an
// AXI4-Stream master, returns one credit per delivered flit and tracks packet boundaries.
module axis_noc_ejection_buffer #(
   parameter int FLIT_WIDTH        = 128,
   parameter int TID_WIDTH         = 2,
   parameter int TDEST_WIDTH       = 4,
   parameter int DEST_WIDTH        = TDEST_WIDTH + TID_WIDTH,
   parameter int FLIT_BUFFER_DEPTH = 2,
   parameter int PKT_COUNT_WIDTH   = 16
) (
   input  logic                       clk_noc,
   input  logic                       rst_noc_sync,
   input  logic [FLIT_WIDTH-1:0]      data_in,
   input  logic [DEST_WIDTH-1:0]      dest_in,
   input  logic                       is_tail_in,
   input  logic                       send_in,
   output logic                       credit_out,
   output logic                       axis_out_tvalid,
   input  logic                       axis_out_tready,
   output logic [FLIT_WIDTH-1:0]      axis_out_tdata,
   output logic                       axis_out_tlast,
   output logic [TID_WIDTH-1:0]       axis_out_tid,
   output logic [TDEST_WIDTH-1:0]     axis_out_tdest,
   output logic                       overflow_err,
   output logic [PKT_COUNT_WIDTH-1:0] pkt_count,
   output logic                       in_packet
);
   localparam int PTR_W   = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
   localparam int CNT_W   = $clog2(FLIT_BUFFER_DEPTH + 1);
   localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FLIT_BUFFER_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FLIT_BUFFER_DEPTH);

   typedef enum logic {S_IDLE, S_IN_PKT} pkt_state_t;

   logic [ENTRY_W-1:0]         r_mem [FLIT_BUFFER_DEPTH];
   logic [PTR_W-1:0]           r_wr_ptr;
   logic [PTR_W-1:0]           r_rd_ptr;
   logic [CNT_W-1:0]           r_count;
   logic                       r_credit;
   logic                       r_overflow;
   logic [PKT_COUNT_WIDTH-1:0] r_pkt_count;
   pkt_state_t                 r_state;
   pkt_state_t                 w_state_next;

   logic                       w_empty;
   logic                       w_full;
   logic                       w_pop;
   logic                       w_push;
   logic                       w_drop;
   logic [ENTRY_W-1:0]         w_head;
   logic [DEST_WIDTH-1:0]      w_head_dest;
   logic                       w_head_tail;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);
   // A full FIFO still accepts a flit when the head leaves in the same cycle.
   assign w_pop   = !rst_noc_sync && !w_empty && axis_out_tready;
   assign w_push  = !rst_noc_sync && send_in && (!w_full || w_pop);
   assign w_drop  = !rst_noc_sync && send_in && w_full && !w_pop;

   assign w_head      = r_mem[r_rd_ptr];
   assign w_head_dest = w_head[DEST_WIDTH:1];
   assign w_head_tail = w_head[0];

   always_ff @(posedge clk_noc) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {data_in, dest_in, is_tail_in};
      end
   end

   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_credit    <= 1'b0;
         r_overflow  <= 1'b0;
         r_pkt_count <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         r_credit <= w_pop;
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         if (w_pop && w_head_tail) begin
            r_pkt_count <= r_pkt_count + PKT_COUNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_pop) begin
         case (r_state)
            S_IDLE:   if (!w_head_tail) w_state_next = S_IN_PKT;
            S_IN_PKT: if (w_head_tail)  w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
         endcase
      end
   end

   assign axis_out_tvalid = !w_empty;
   assign axis_out_tdata  = w_head[ENTRY_W-1 -: FLIT_WIDTH];
   assign axis_out_tid    = w_head_dest[DEST_WIDTH-1:TDEST_WIDTH];
   assign axis_out_tdest  = w_head_dest[TDEST_WIDTH-1:0];
   assign axis_out_tlast  = w_head_tail;
   assign credit_out      = r_credit;
   assign overflow_err    = r_overflow;
   assign pkt_count       = r_pkt_count;
   assign in_packet       = (r_state == S_IN_PKT);
endmodule

// File: tb/tb_axis_noc_ejection_buffer.sv
// Bench for axis_noc_ejection_buffer: hand-derived vector table plus a flit scoreboard
// checked every cycle, and a packet-counter wrap sequence.
module tb_axis_noc_ejection_buffer;
   localparam int FW    = 128;
   localparam int TIDW  = 2;
   localparam int TDW   = 4;
   localparam int DW    = TIDW + TDW;
   localparam int DEPTH = 2;
   localparam int PCW   = 8;
   localparam int NVEC  = 31;

   logic            clk_noc = 1'b0;
   logic            rst_noc_sync;
   logic [FW-1:0]   data_in;
   logic [DW-1:0]   dest_in;
   logic            is_tail_in;
   logic            send_in;
   logic            credit_out;
   logic            axis_out_tvalid;
   logic            axis_out_tready;
   logic [FW-1:0]   axis_out_tdata;
   logic            axis_out_tlast;
   logic [TIDW-1:0] axis_out_tid;
   logic [TDW-1:0]  axis_out_tdest;
   logic            overflow_err;
   logic [PCW-1:0]  pkt_count;
   logic            in_packet;

   always #5 clk_noc = ~clk_noc;

   axis_noc_ejection_buffer #(
      .FLIT_WIDTH(FW), .TID_WIDTH(TIDW), .TDEST_WIDTH(TDW), .DEST_WIDTH(DW),
      .FLIT_BUFFER_DEPTH(DEPTH), .PKT_COUNT_WIDTH(PCW)
   ) dut (
      .clk_noc(clk_noc), .rst_noc_sync(rst_noc_sync),
      .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
      .credit_out(credit_out),
      .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
      .axis_out_tdata(axis_out_tdata), .axis_out_tlast(axis_out_tlast),
      .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest),
      .overflow_err(overflow_err), .pkt_count(pkt_count), .in_packet(in_packet)
   );

   typedef struct {
      logic [FW-1:0] data;
      logic [DW-1:0] dest;
      logic          tail;
   } flit_t;

   typedef struct {
      logic           rst;
      logic           send;
      logic [7:0]     db;
      logic [DW-1:0]  dest;
      logic           tail;
      logic           rdy;
      logic           v;
      logic           c;
      logic           o;
      logic [PCW-1:0] p;
      logic           ip;
   } vec_t;

   flit_t          sb_q[$];
   logic           m_credit;
   logic           m_ovf;
   logic           m_inpkt;
   logic [PCW-1:0] m_pkt;
   int             n_vec  = 0;
   int             n_fail = 0;
   vec_t           tbl[NVEC];

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic rst, input logic send, input logic [7:0] db,
                                input logic [DW-1:0] dest, input logic tail, input logic rdy,
                                input logic v, input logic c, input logic o,
                                input logic [PCW-1:0] p, input logic ip);
      vec_t r;
      r.rst = rst; r.send = send; r.db = db; r.dest = dest; r.tail = tail; r.rdy = rdy;
      r.v = v; r.c = c; r.o = o; r.p = p; r.ip = ip;
      return r;
   endfunction

   // Advance one clock: update the scoreboard from the inputs in force, then check the DUT.
   task automatic tick();
      int    sz;
      logic  pop;
      flit_t f;
      sz  = sb_q.size();
      pop = !rst_noc_sync && (sz != 0) && axis_out_tready;
      if (rst_noc_sync) begin
         sb_q.delete();
         m_credit = 1'b0;
         m_ovf    = 1'b0;
         m_pkt    = '0;
         m_inpkt  = 1'b0;
      end else begin
         m_credit = pop;
         if (pop) begin
            f = sb_q.pop_front();
            if (f.tail) begin
               m_pkt   = m_pkt + PCW'(1);
               m_inpkt = 1'b0;
            end else begin
               m_inpkt = 1'b1;
            end
         end
         if (send_in) begin
            if (sz < DEPTH || pop) begin
               f.data = data_in;
               f.dest = dest_in;
               f.tail = is_tail_in;
               sb_q.push_back(f);
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
      @(posedge clk_noc);
      #1;
      chk("sb tvalid", FW'(axis_out_tvalid), FW'(sb_q.size() != 0));
      chk("sb credit", FW'(credit_out), FW'(m_credit));
      chk("sb overflow", FW'(overflow_err), FW'(m_ovf));
      chk("sb pkt_count", FW'(pkt_count), FW'(m_pkt));
      chk("sb in_packet", FW'(in_packet), FW'(m_inpkt));
      if (sb_q.size() != 0) begin
         chk("sb tdata", axis_out_tdata, sb_q[0].data);
         chk("sb tid", FW'(axis_out_tid), FW'(sb_q[0].dest[DW-1:TDW]));
         chk("sb tdest", FW'(axis_out_tdest), FW'(sb_q[0].dest[TDW-1:0]));
         chk("sb tlast", FW'(axis_out_tlast), FW'(sb_q[0].tail));
      end
   endtask

   initial begin
      rst_noc_sync = 1'b1; send_in = 1'b0; data_in = '0; dest_in = '0;
      is_tail_in = 1'b0; axis_out_tready = 1'b0;
      m_credit = 1'b0; m_ovf = 1'b0; m_inpkt = 1'b0; m_pkt = '0;

      //              rst send db     dest    tl rdy  v  c  o  pkt ip
      tbl[0]  = mkv(1, 1, 8'h00, 6'h00, 0, 1,  0, 0, 0, 0, 0);
      tbl[1]  = mkv(1, 0, 8'h00, 6'h00, 0, 0,  0, 0, 0, 0, 0);
      tbl[2]  = mkv(0, 1, 8'hA5, 6'h23, 1, 1,  1, 0, 0, 0, 0);
      tbl[3]  = mkv(0, 0, 8'h00, 6'h00, 0, 1,  0, 1, 0, 1, 0);
      tbl[4]  = mkv(0, 0, 8'h00, 6'h00, 0, 0,  0, 0, 0, 1, 0);
      tbl[5]  = mkv(0, 1, 8'h11, 6'h15, 0, 0,  1, 0, 0, 1, 0);
      tbl[6]  = mkv(0, 1, 8'h22, 6'h2A, 1, 0,  1, 0, 0, 1, 0);
      tbl[7]  = mkv(0, 0, 8'h00, 6'h00, 0, 0,  1, 0, 0, 1, 0);
      tbl[8]  = mkv(0, 1, 8'h33, 6'h3F, 1, 0,  1, 0, 1, 1, 0);
      tbl[9]  = mkv(0, 0, 8'h00, 6'h00, 0, 0,  1, 0, 1, 1, 0);
      tbl[10] = mkv(0, 0, 8'h00, 6'h00, 0, 1,  1, 1, 1, 1, 1);
      tbl[11] = mkv(0, 0, 8'h00, 6'h00, 0, 1,  0, 1, 1, 2, 0);
      tbl[12] = mkv(0, 0, 8'h00, 6'h00, 0, 1,  0, 0, 1, 2, 0);
      tbl[13] = mkv(1, 0, 8'h00, 6'h00, 0, 0,  0, 0, 0, 0, 0);
      tbl[14] = mkv(0, 1, 8'h44, 6'h01, 0, 0,  1, 0, 0, 0, 0);
      tbl[15] = mkv(0, 1, 8'h55, 6'h12, 0, 0,  1, 0, 0, 0, 0);
      tbl[16] = mkv(0, 1, 8'h66, 6'h24, 1, 1,  1, 1, 0, 0, 1);
      tbl[17] = mkv(0, 0, 8'h00, 6'h00, 0, 0,  1, 0, 0, 0, 1);
      tbl[18] = mkv(0, 0, 8'h00, 6'h00, 0, 1,  1, 1, 0, 0, 1);
      tbl[19] = mkv(0, 0, 8'h00, 6'h00, 0, 1,  0, 1, 0, 1, 0);
      tbl[20] = mkv(0, 1, 8'h71, 6'h30, 0, 1,  1, 0, 0, 1, 0);
      tbl[21] = mkv(0, 1, 8'h72, 6'h30, 0, 1,  1, 1, 0, 1, 1);
      tbl[22] = mkv(0, 1, 8'h73, 6'h30, 1, 1,  1, 1, 0, 1, 1);
      tbl[23] = mkv(0, 1, 8'h74, 6'h0F, 1, 1,  1, 1, 0, 2, 0);
      tbl[24] = mkv(0, 0, 8'h00, 6'h00, 0, 1,  0, 1, 0, 3, 0);
      tbl[25] = mkv(0, 0, 8'h00, 6'h00, 0, 1,  0, 0, 0, 3, 0);
      tbl[26] = mkv(0, 1, 8'h81, 6'h05, 0, 0,  1, 0, 0, 3, 0);
      tbl[27] = mkv(0, 1, 8'h82, 6'h05, 0, 1,  1, 1, 0, 3, 1);
      tbl[28] = mkv(0, 1, 8'h83, 6'h05, 0, 0,  1, 0, 0, 3, 1);
      tbl[29] = mkv(1, 1, 8'h84, 6'h05, 1, 1,  0, 0, 0, 0, 0);
      tbl[30] = mkv(0, 0, 8'h00, 6'h00, 0, 1,  0, 0, 0, 0, 0);

      for (int i = 0; i < NVEC; i++) begin
         rst_noc_sync    = tbl[i].rst;
         send_in         = tbl[i].send;
         data_in         = {16{tbl[i].db}};
         dest_in         = tbl[i].dest;
         is_tail_in      = tbl[i].tail;
         axis_out_tready = tbl[i].rdy;
         tick();
         $display("vec %0d: rst=%0b send=%0b rdy=%0b -> tvalid=%0b credit=%0b ovf=%0b pkt=%0d inpkt=%0b",
                  i, tbl[i].rst, tbl[i].send, tbl[i].rdy, axis_out_tvalid, credit_out,
                  overflow_err, pkt_count, in_packet);
         chk($sformatf("row%0d tvalid", i), FW'(axis_out_tvalid), FW'(tbl[i].v));
         chk($sformatf("row%0d credit", i), FW'(credit_out), FW'(tbl[i].c));
         chk($sformatf("row%0d overflow", i), FW'(overflow_err), FW'(tbl[i].o));
         chk($sformatf("row%0d pkt_count", i), FW'(pkt_count), FW'(tbl[i].p));
         chk($sformatf("row%0d in_packet", i), FW'(in_packet), FW'(tbl[i].ip));
         if (i == 2) begin
            chk("single tid", FW'(axis_out_tid), FW'(2'd2));
            chk("single tdest", FW'(axis_out_tdest), FW'(4'd3));
            chk("single tlast", FW'(axis_out_tlast), FW'(1'b1));
            chk("single tdata", axis_out_tdata, {16{8'hA5}});
         end
      end

      // Stream 256 single-flit packets back to back to wrap the packet counter.
      rst_noc_sync    = 1'b0;
      send_in         = 1'b1;
      is_tail_in      = 1'b1;
      axis_out_tready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
         dest_in = DW'($urandom());
         tick();
      end
      $display("wrap: after 255 pops pkt_count=%0h", pkt_count);
      chk("wrap before", FW'(pkt_count), FW'(8'hFF));
      send_in = 1'b0;
      tick();
      $display("wrap: after 256 pops pkt_count=%0h", pkt_count);
      chk("wrap after", FW'(pkt_count), FW'(8'h00));
      tick();
      chk("wrap drained tvalid", FW'(axis_out_tvalid), FW'(1'b0));
      chk("wrap drained credit", FW'(credit_out), FW'(1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
